// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Ports: CLK, RST (async, active-low), flush, in_valid/in_ready/op/src_a/src_b/rd_in, out_valid/out_ready/result/rd_out.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_res;
  logic [4:0]        r_rd_out;
  logic              r_in_ready;
  logic              r_out_valid;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_res;
  assign rd_out    = r_rd_out;

  // accept-time decode
  logic            w_is_div;
  logic            w_a_sop;
  logic            w_b_sop;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec;

  assign w_is_div = op[2];
  assign w_a_sop  = (op == 3'd1) | (op == 3'd2)
                  | (op == 3'd4) | (op == 3'd6);
  assign w_b_sop  = (op == 3'd1) | (op == 3'd4)
                  | (op == 3'd6);
  assign w_a_neg  = w_a_sop & src_a[XLEN-1];
  assign w_b_neg  = w_b_sop & src_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -src_a : src_a;
  assign w_b_mag  = w_b_neg ? -src_b : src_b;
  assign w_div0   = w_is_div & (src_b == '0);
  assign w_ovf    = w_is_div & ~op[0]
                  & (src_a == {1'b1, {(XLEN-1){1'b0}}})
                  & (&src_b);
  // op[1] selects remainder among the divide ops
  assign w_spec   = w_div0 ? (op[1] ? src_a : '1)
                           : (op[1] ? '0 : src_a);

  // multiply step: add multiplicand into high half, shift pair right
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_mhi;
  logic [XLEN-1:0] w_mlo;

  assign w_sum = {1'b0, r_hi}
               + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_mhi = w_sum[XLEN:1];
  assign w_mlo = {w_sum[0], r_lo[XLEN-1:1]};

  // restoring divide step; a set top bit always exceeds the divisor
  logic [XLEN:0]   w_shr;
  logic            w_qb;
  logic [XLEN-1:0] w_dif;
  logic [XLEN-1:0] w_dhi;
  logic [XLEN-1:0] w_dlo;

  assign w_shr = {r_hi, r_lo[XLEN-1]};
  assign w_qb  = w_shr[XLEN] | (w_shr[XLEN-1:0] >= r_a);
  assign w_dif = w_shr[XLEN-1:0] - r_a;
  assign w_dhi = w_qb ? w_dif : w_shr[XLEN-1:0];
  assign w_dlo = {r_lo[XLEN-2:0], w_qb};

  logic [XLEN-1:0]   w_nhi;
  logic [XLEN-1:0]   w_nlo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_fin;

  assign w_nhi    = r_op[2] ? w_dhi : w_mhi;
  assign w_nlo    = r_op[2] ? w_dlo : w_mlo;
  assign w_prod   = {w_mhi, w_mlo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_q      = r_neg_q ? -w_dlo : w_dlo;
  assign w_r      = r_neg_r ? -w_dhi : w_dhi;

  always_comb begin
    w_fin = '0;
    unique case (1'b1)
      (r_op == 3'd0): w_fin = w_prod_s[XLEN-1:0];
      (r_op[2] == 1'b0 && r_op != 3'd0):
        w_fin = w_prod_s[2*XLEN-1:XLEN];
      (r_op[2] && !r_op[1]): w_fin = w_q;
      (r_op[2] && r_op[1]):  w_fin = w_r;
      default: w_fin = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_a         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_res       <= '0;
      r_rd_out    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= op;
            r_rd       <= rd_in;
            r_cnt      <= '0;
            r_a        <= w_is_div ? w_b_mag : w_a_mag;
            r_hi       <= '0;
            r_lo       <= w_is_div ? w_a_mag : w_b_mag;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_in_ready <= 1'b0;
            if (w_div0 | w_ovf) begin
              r_res       <= w_spec;
              r_rd_out    <= rd_in;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(XLEN-1)) begin
            r_res       <= w_fin;
            r_rd_out    <= r_rd;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic, special cases,
// backpressure, flush and asynchronous reset.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  muldiv_unit dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_out    (rd_out)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, check, then retire it.
  // Latency is counted in edges after the accept edge.
  task automatic run_op(input string tag,
                        input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input logic [31:0] exp,
                        input int exp_lat);
    int lat;
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    op       = o;
    src_a    = a;
    src_b    = b;
    rd_in    = rd;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    src_a    = 32'hDEAD_BEEF;
    src_b    = 32'h1234_5678;
    op       = ~o;
    rd_in    = ~rd;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check({tag, " retire"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int lat;
    logic seen;
    RST       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 3'd0;
    src_a     = '0;
    src_b     = '0;
    rd_in     = '0;
    #12;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst rd_out", {27'd0, rd_out}, 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 32);
    run_op("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, 32);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 32);
    run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 32);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 32);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 32);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd10, 32'd14, 32);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 5'd11, 32'd2, 32);
    run_op("REM 7/-2", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'd1, 32);
    run_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 0);
    run_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 5'd14, 32'd5, 0);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd0, 0);

    // backpressure: result held while out_ready=0
    op = 3'd0; src_a = 32'd3; src_b = 32'd5; rd_in = 5'd9;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    src_a = '0; src_b = '0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("hold latency", lat, 32);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      check("hold result", result, 32'd15);
      check("hold rd_out", {27'd0, rd_out}, 32'd9);
      check("hold flags", {30'd0, in_ready, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check("hold release", {30'd0, in_ready, out_valid}, 32'd2);
    check("hold keep result", result, 32'd15);

    // flush in BUSY
    op = 3'd5; src_a = 32'd100; src_b = 32'd7; rd_in = 5'd21;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
    end
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    check("flush state", {30'd0, in_ready, out_valid}, 32'd2);
    seen = 1'b0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush no valid", {31'd0, seen}, 32'd0);
    check("flush rd_out", {27'd0, rd_out}, 32'd9);

    // flush beats accept
    op = 3'd0; src_a = 32'd2; src_b = 32'd2; rd_in = 5'd1;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush blocks accept", {30'd0, in_ready, out_valid}, 32'd2);

    // asynchronous reset mid-BUSY
    op = 3'd0; src_a = 32'd6; src_b = 32'd7; rd_in = 5'd22;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge CLK); #1;
    end
    #2 RST = 1'b0;
    #1;
    check("arst in_ready", {31'd0, in_ready}, 32'd1);
    check("arst out_valid", {31'd0, out_valid}, 32'd0);
    check("arst result", result, 32'd0);
    check("arst rd_out", {27'd0, rd_out}, 32'd0);
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    run_op("post-rst DIVU", 3'd5, 32'd100, 32'd7, 5'd23, 32'd14, 32);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
